// File: rtl/exp_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exp_align_ctrl
// Description : Exponent-alignment controller for a floating-point adder.
//               Accepts an operand pair (biased exponents and mantissas with
//               hidden bit). It compares the exponents on a shared external
//               ripple-carry subtractor and then right-shifts the mantissa of
//               the smaller-exponent operand one bit per cycle. Bits shifted
//               out are accumulated into a sticky bit. The aligned result is
//               then presented with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   clock, rising-edge active
//   rst_n         in   1   asynchronous active-low reset
//   in_valid      in   1   operand pair valid
//   in_ready      out  1   block can accept an operand pair (IDLE only)
//   exp_a, exp_b  in   EW  biased exponents
//   man_a, man_b  in   MW  mantissas including hidden bit
//   sub_a, sub_b  out  EW  operands to the external subtractor (a - b)
//   sub_diff      in   EW  subtractor difference
//   sub_cout      in   1   subtractor carry-out, 1 = no borrow (a >= b)
//   out_valid     out  1   aligned result valid (DONE only)
//   out_ready     in   1   consumer accepts the result
//   out_exp       out  EW  larger exponent
//   out_man_big   out  MW  mantissa of the larger-exponent operand
//   out_man_small out  MW  aligned mantissa of the smaller-exponent operand
//   out_sticky    out  1   OR of all bits shifted out of out_man_small
//   out_swap      out  1   operands were exchanged (exp_b > exp_a)
// ============================================================================
module exp_align_ctrl #(
  parameter int EW = 5,
  parameter int MW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  input  logic [MW-1:0] man_a,
  input  logic [MW-1:0] man_b,
  output logic [EW-1:0] sub_a,
  output logic [EW-1:0] sub_b,
  input  logic [EW-1:0] sub_diff,
  input  logic          sub_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_exp,
  output logic [MW-1:0] out_man_big,
  output logic [MW-1:0] out_man_small,
  output logic          out_sticky,
  output logic          out_swap
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SUB1  = 3'd1,
    S_SUB2  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Shift distances above this flush the whole mantissa in a single cycle.
  localparam logic [31:0] c_mw_limit = 32'(MW);

  state_t        state_q, state_d;
  logic [EW-1:0] exp_a_q, exp_a_d;
  logic [EW-1:0] exp_b_q, exp_b_d;
  logic [MW-1:0] man_a_q, man_a_d;
  logic [MW-1:0] man_b_q, man_b_d;
  logic [EW-1:0] diff_q, diff_d;
  logic [EW-1:0] exp_big_q, exp_big_d;
  logic [MW-1:0] man_big_q, man_big_d;
  logic [MW-1:0] man_small_q, man_small_d;
  logic          sticky_q, sticky_d;
  logic          swap_q, swap_d;

  logic [31:0]   diff_ext;

  assign diff_ext = 32'(diff_q);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
      diff_q      <= '0;
      exp_big_q   <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      sticky_q    <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      man_a_q     <= man_a_d;
      man_b_q     <= man_b_d;
      diff_q      <= diff_d;
      exp_big_q   <= exp_big_d;
      man_big_q   <= man_big_d;
      man_small_q <= man_small_d;
      sticky_q    <= sticky_d;
      swap_q      <= swap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    man_a_d     = man_a_q;
    man_b_d     = man_b_q;
    diff_d      = diff_q;
    exp_big_d   = exp_big_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    sticky_d    = sticky_q;
    swap_d      = swap_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sub_a       = '0;
    sub_b       = '0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          exp_a_d  = exp_a;
          exp_b_d  = exp_b;
          man_a_d  = man_a;
          man_b_d  = man_b;
          sticky_d = 1'b0;
          state_d  = S_SUB1;
        end
      end

      S_SUB1: begin
        sub_a = exp_a_q;
        sub_b = exp_b_q;
        if (sub_cout) begin
          // exp_a >= exp_b: operand A is the big one, no exchange.
          swap_d      = 1'b0;
          diff_d      = sub_diff;
          exp_big_d   = exp_a_q;
          man_big_d   = man_a_q;
          man_small_d = man_b_q;
          state_d     = (sub_diff == '0) ? S_DONE : S_SHIFT;
        end else begin
          // Borrow: B is larger, recompute the difference the other way round
          // so the shift distance comes out positive.
          swap_d  = 1'b1;
          state_d = S_SUB2;
        end
      end

      S_SUB2: begin
        sub_a       = exp_b_q;
        sub_b       = exp_a_q;
        diff_d      = sub_diff;
        exp_big_d   = exp_b_q;
        man_big_d   = man_b_q;
        man_small_d = man_a_q;
        state_d     = S_SHIFT;
      end

      S_SHIFT: begin
        if (diff_ext > c_mw_limit) begin
          // Everything shifts out; collapse it into one cycle.
          man_small_d = '0;
          sticky_d    = sticky_q | (|man_small_q);
          state_d     = S_DONE;
        end else if (diff_q == '0) begin
          // Not reachable in normal flow; leave safely.
          state_d = S_DONE;
        end else begin
          man_small_d = {1'b0, man_small_q[MW-1:1]};
          sticky_d    = sticky_q | man_small_q[0];
          diff_d      = diff_q - 1'b1;
          if (diff_q == EW'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_exp       = exp_big_q;
  assign out_man_big   = man_big_q;
  assign out_man_small = man_small_q;
  assign out_sticky    = sticky_q;
  assign out_swap      = swap_q;

endmodule
`default_nettype wire

// File: tb/tb_exp_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_align_ctrl
// Description : Self-checking bench for exp_align_ctrl. Models the external
//               subtractor and applies a table of directed operand pairs with
//               hand-computed results. It also runs hand-written sequences
//               for output back-pressure and for a reset during shifting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_align_ctrl;

  localparam int EW = 5;
  localparam int MW = 11;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] exp_a, exp_b;
  logic [MW-1:0] man_a, man_b;
  logic [EW-1:0] sub_a, sub_b;
  logic [EW-1:0] sub_diff;
  logic          sub_cout;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_man_big;
  logic [MW-1:0] out_man_small;
  logic          out_sticky;
  logic          out_swap;

  int n_cmp = 0;
  int n_bad = 0;

  exp_align_ctrl #(.EW(EW), .MW(MW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .exp_a         (exp_a),
    .exp_b         (exp_b),
    .man_a         (man_a),
    .man_b         (man_b),
    .sub_a         (sub_a),
    .sub_b         (sub_b),
    .sub_diff      (sub_diff),
    .sub_cout      (sub_cout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_exp       (out_exp),
    .out_man_big   (out_man_big),
    .out_man_small (out_man_small),
    .out_sticky    (out_sticky),
    .out_swap      (out_swap)
  );

  // External ripple-carry subtractor
  assign sub_diff = sub_a - sub_b;
  assign sub_cout = (sub_a >= sub_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic [EW-1:0] oexp;
    logic [MW-1:0] obig;
    logic [MW-1:0] osmall;
    logic          ostk;
    logic          oswap;
    int            lat;   // cycles from transfer edge t to first out_valid
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Applies one operand pair and checks latency and results. With hold set,
  // the result is back-pressured for five cycles before being accepted.
  task automatic run_vec(input vec_t v, input bit hold);
    int            edges;
    logic [EW-1:0] h_exp;
    logic [MW-1:0] h_big, h_small;
    logic          h_stk, h_swap;
    edges = 0;
    while (!in_ready && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
    chk("in_ready_before_transfer", 32'(in_ready), 32'd1);
    exp_a = v.ea; exp_b = v.eb; man_a = v.ma; man_b = v.mb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;
    chk("sub_a_in_sub1", 32'(sub_a), 32'(v.ea));
    chk("sub_b_in_sub1", 32'(sub_b), 32'(v.eb));
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    edges = 0;
    if (v.oswap) begin
      @(posedge clk); #1; edges = 1;
      chk("sub_a_in_sub2", 32'(sub_a), 32'(v.eb));
      chk("sub_b_in_sub2", 32'(sub_b), 32'(v.ea));
    end
    while (!out_valid && edges < 60) begin
      @(posedge clk); #1; edges++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("latency", 32'(edges + 1), 32'(v.lat));
    chk("out_exp", 32'(out_exp), 32'(v.oexp));
    chk("out_man_big", 32'(out_man_big), 32'(v.obig));
    chk("out_man_small", 32'(out_man_small), 32'(v.osmall));
    chk("out_sticky", 32'(out_sticky), 32'(v.ostk));
    chk("out_swap", 32'(out_swap), 32'(v.oswap));
    chk("sub_a_zero_done", 32'(sub_a), 32'd0);
    if (hold) begin
      h_exp = out_exp; h_big = out_man_big; h_small = out_man_small;
      h_stk = out_sticky; h_swap = out_swap;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_data", {out_exp, out_man_big, out_man_small, out_sticky, out_swap} & 32'hFFFF_FFFF,
            {h_exp, h_big, h_small, h_stk, h_swap} & 32'hFFFF_FFFF);
        chk("hold_small", 32'(out_man_small), 32'(h_small));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    //            ea     eb     ma       mb       oexp   obig     osmall   stk   swp   lat
    vecs[0] = '{5'd15, 5'd12, 11'h400, 11'h600, 5'd15, 11'h400, 11'h0C0, 1'b0, 1'b0, 5};
    vecs[1] = '{5'd10, 5'd13, 11'h401, 11'h500, 5'd13, 11'h500, 11'h080, 1'b1, 1'b1, 6};
    vecs[2] = '{5'd7,  5'd7,  11'h4AA, 11'h555, 5'd7,  11'h4AA, 11'h555, 1'b0, 1'b0, 2};
    vecs[3] = '{5'd30, 5'd1,  11'h123, 11'h7FF, 5'd30, 11'h123, 11'h000, 1'b1, 1'b0, 3};
    // diff == MW: shifted bit by bit, everything leaves
    vecs[4] = '{5'd20, 5'd9,  11'h456, 11'h7FF, 5'd20, 11'h456, 11'h000, 1'b1, 1'b0, 13};
    // diff == MW+1: single flush cycle
    vecs[5] = '{5'd21, 5'd9,  11'h456, 11'h001, 5'd21, 11'h456, 11'h000, 1'b1, 1'b0, 3};
    // diff == 1 with swap
    vecs[6] = '{5'd4,  5'd5,  11'h003, 11'h444, 5'd5,  11'h444, 11'h001, 1'b1, 1'b1, 4};
    // max distance with swap, zero mantissa leaves sticky clear
    vecs[7] = '{5'd0,  5'd31, 11'h000, 11'h7FF, 5'd31, 11'h7FF, 11'h000, 1'b0, 1'b1, 4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({out_exp, out_man_big, out_man_small, out_sticky, out_swap}), 32'd0);
    chk("rst_sub", 32'({sub_a, sub_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], 1'b0);
    end

    // Back-pressure in DONE
    run_vec(vecs[0], 1'b1);

    // Reset in the middle of SHIFT (diff = 11)
    exp_a = 5'd20; exp_b = 5'd9; man_a = 11'h456; man_b = 11'h7FF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({out_exp, out_man_big, out_man_small, out_sticky, out_swap}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    out_ready = 1'b0;
    chk("no_result_after_reset", 32'(cnt), 32'd0);

    run_vec(vecs[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/exp_align_ctrl.md
EXP_ALIGN_CTRL -- requirements
Module: exp_align_ctrl

Interface
REQ-001 The block SHALL use parameters: EW, default 5, exponent width; MW, default 11, mantissa width including hidden bit.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- exp_a, exp_b  input  EW each  biased exponents.
- man_a, man_b  input  MW each  mantissas.
- sub_a, sub_b  output  EW each  operands driven to the shared external EW-bit ripple-carry subtractor (sub_a minus sub_b).
- sub_diff  input  EW  subtractor difference.
- sub_cout  input  1  subtractor carry-out; 1 means no borrow (sub_a >= sub_b).
- out_valid  output  1  aligned result valid.
- out_ready  input  1  consumer accepts the result.
- out_exp  output  EW  larger exponent.
- out_man_big  output  MW  mantissa of the larger-exponent operand.
- out_man_small  output  MW  right-shifted mantissa of the smaller-exponent operand.
- out_sticky  output  1  OR of all bits shifted out of out_man_small.
- out_swap  output  1  1 when the operands were exchanged (exp_b > exp_a).

Function
REQ-003 The FSM SHALL have five states: IDLE, SUB1, SUB2, SHIFT and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid=1 and in_ready=1 at a rising edge, which registers all four operands and enters SUB1.
REQ-005 In SUB1, sub_a SHALL equal the registered exp_a and sub_b the registered exp_b; in SUB2 they SHALL be exchanged; in all other states both SHALL be 0.
REQ-006 In SUB1 with sub_cout=1, the block SHALL:
- set swap=0 and latch diff=sub_diff;
- take big=exp_a/man_a and small=man_b;
- go to DONE if diff=0, otherwise to SHIFT.
REQ-007 In SUB1 with sub_cout=0, the block SHALL go to SUB2 and set swap=1.
REQ-008 In SUB2, the block SHALL latch diff=sub_diff, take big=exp_b/man_b and small=man_a, and go to SHIFT (diff is nonzero there).
REQ-009 On entering SHIFT with diff > MW, the block SHALL spend one cycle that sets small=0 and sticky=OR of all bits of small, then goes to DONE.
REQ-010 Otherwise, each SHIFT cycle SHALL shift small right by one with zero fill, OR the shifted-out LSB into sticky, and decrement diff, going to DONE when diff reaches 0.
REQ-011 out_valid SHALL be 1 only in DONE; DONE SHALL go to IDLE on out_valid and out_ready, and no new operands SHALL be accepted in that same cycle.
REQ-012 All out_* data SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-013 For a transfer at edge t, out_valid SHALL first be 1 in cycle t+2+s+k, where:
- s=1 if swap, else 0;
- k=0 if diff=0, k=diff if 1<=diff<=MW, k=1 if diff>MW.
REQ-014 sticky SHALL be cleared on every input transfer.
REQ-015 Equal exponents SHALL give swap=0, out_man_small=man_b and out_sticky=0.

Reset
REQ-016 While rst_n=0, regardless of clk, the block SHALL:
- be in IDLE;
- drive in_ready=1 and out_valid=0;
- drive out_exp, out_man_big, out_man_small, out_sticky, out_swap, sub_a and sub_b to 0.
REQ-017 Reset asserted in any state, including mid-SHIFT, SHALL abandon the operation with no output transfer.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- exp_a=15, exp_b=12, man_a=0x400, man_b=0x600 -> out_exp=15, out_man_big=0x400, out_man_small=0x0C0, out_sticky=0, out_swap=0, out_valid at t+5.
- exp_a=10, exp_b=13, man_a=0x401, man_b=0x500 -> out_exp=13, out_man_big=0x500, out_man_small=0x080, out_sticky=1, out_swap=1, out_valid at t+6.
- exp_a=7, exp_b=7, man_a=0x4AA, man_b=0x555 -> out_man_small=0x555, out_sticky=0, out_swap=0, out_valid at t+2.
- exp_a=30, exp_b=1, man_b=0x7FF -> out_man_small=0, out_sticky=1, out_valid at t+3.
- out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE the next cycle.
- rst_n pulsed low during SHIFT -> immediately in_ready=1 and out_valid=0; no result is emitted; the next operand pair is processed correctly.
